// File: rtl/cdbus_bus_emu.sv
// N-node shared-bus emulator: resolves tx/tx_en pairs into one delayed bus value,
// flags push-pull contention and can invert the bus for a requested number of cycles.
module cdbus_bus_emu #(
    parameter int N_NODES = 3,
    parameter int DELAY   = 2,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_NODES-1:0] tx,
    input  logic [N_NODES-1:0] tx_en,
    output logic [N_NODES-1:0] rx,
    input  logic               mode,
    output logic               bus_out,
    output logic               conflict,
    output logic [CNT_W-1:0]   conflict_cnt,
    input  logic               clr_cnt,
    input  logic               inj_req,
    input  logic [LEN_W-1:0]   inj_len,
    output logic               inj_ack,
    output logic               inj_busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } inj_state_t;

    inj_state_t         inj_state;
    logic [LEN_W-1:0]   inj_cnt;
    logic [DELAY-1:0]   pipe;
    logic               any_drv0;
    logic               any_drv1;
    logic               res;
    logic               contention;
    logic               contention_rise;

    // Both modes collapse to "any enabled zero pulls the bus low": open-drain by
    // nature, push-pull because disagreement resolves to 0. Mode only gates contention.
    always_comb begin
        any_drv0   = |(tx_en & ~tx);
        any_drv1   = |(tx_en & tx);
        res        = ~any_drv0;
        contention = ~mode & any_drv0 & any_drv1;
    end

    assign contention_rise = contention & ~conflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '1;
        end else begin
            pipe[0] <= res;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            conflict <= contention;
            if (clr_cnt) begin
                conflict_cnt <= '0;
            end else if (contention_rise && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    // The ack cycle sits between the request and the first inverted cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_state <= IDLE;
            inj_cnt   <= '0;
            inj_ack   <= 1'b0;
            inj_busy  <= 1'b0;
        end else begin
            inj_ack <= 1'b0;
            case (inj_state)
                IDLE: begin
                    if (inj_ack) begin
                        inj_state <= ACTIVE;
                        inj_busy  <= 1'b1;
                    end else if (inj_req && (inj_len != '0)) begin
                        inj_ack <= 1'b1;
                        inj_cnt <= inj_len;
                    end
                end
                ACTIVE: begin
                    if (inj_cnt == LEN_W'(1)) begin
                        inj_state <= IDLE;
                        inj_busy  <= 1'b0;
                    end else begin
                        inj_cnt <= inj_cnt - LEN_W'(1);
                    end
                end
                default: begin
                    inj_state <= IDLE;
                    inj_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_out = pipe[DELAY-1] ^ inj_busy;
    assign rx      = (tx_en & tx) | (~tx_en & {N_NODES{bus_out}});

endmodule
